imem_responder: RTL
===================

# imem_responder

Synthesizable instruction-memory responder for the fetch side of the RISC-V core. It samples the program counter (`pc`) driven by the core and returns the addressed 32-bit instruction word one cycle later. This completes the fetch protocol in which the core drives `pc` and consumes `instr`. It has a loader port used to program the memory after reset, a LOAD/RUN state machine, fault flagging for misaligned or out-of-range fetches, and a fetch counter.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the memory; must be a power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.
- `NOP_INSTR`, 32'h0000_0013: word returned on fault or while not running (`addi x0,x0,0`).

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  in  32  byte fetch address from the core.
- `instr`  out  32  fetched instruction, registered.
- `instr_valid`  out  1  `instr` corresponds to a `pc` sampled in RUN.
- `fault`  out  1  the `pc` that produced the current `instr` was misaligned or out of range.
- `ld_valid`  in  1  loader beat valid.
- `ld_ready`  out  1  responder accepts loader beats.
- `ld_addr`  in  32  word index for the loader write.
- `ld_data`  in  32  instruction word to write.
- `ld_last`  in  1  final loader beat.
- `ld_err`  out  1  sticky: a loader beat targeted `ld_addr` ≥ `DEPTH_WORDS`.
- `run`  out  1  state is RUN.
- `fetch_count`  out  32  count of non-faulting RUN fetches; saturating.

## Operation
- States: LOAD (reset state) and RUN. There is no other exit from RUN; only `reset` returns the block to LOAD.
- LOAD:
  - `ld_ready`=1. A beat is accepted when `ld_valid`&&`ld_ready`.
  - An accepted beat with `ld_addr` < `DEPTH_WORDS` writes `mem[ld_addr]`=`ld_data`. Otherwise the write is dropped and `ld_err` is set.
  - An accepted beat with `ld_last`=1 transitions to RUN on the same edge. Its write (if in range) still occurs.
  - `pc` is ignored in LOAD.
- RUN:
  - `ld_ready`=0; `ld_valid` is ignored.
  - Each edge, compute `off` = `pc` − `BASE_ADDR` (32-bit unsigned, wraps). A `pc` below `BASE_ADDR` therefore lands out of range.
  - Fault if `pc[1:0]`≠0 or `off[31:2]` ≥ `DEPTH_WORDS`. On fault: `instr`←`NOP_INSTR`, `fault`←1.
  - Otherwise `instr`←`mem[off[31:2]]`, `fault`←0, and `fetch_count` increments unless it is already 32'hFFFF_FFFF.
  - `instr_valid`←1 every RUN edge.
- Memory contents are not cleared by `reset`. Words never written read as unknown/0; this is implementation-defined and benches must not rely on it.

## Timing
- Reset values: state=LOAD, `instr`=`NOP_INSTR`, `instr_valid`=0, `fault`=0, `ld_err`=0, `fetch_count`=0, `run`=0, `ld_ready`=1 (combinational from state).
- Fetch latency is 1 cycle: `pc` sampled at edge N produces `instr`/`fault`/`instr_valid` valid after edge N, held until edge N+1. One fetch per cycle, no stalls.
- The first RUN fetch is sampled on the edge after the `ld_last` acceptance edge. `run` rises on the acceptance edge itself.
- While in LOAD, `instr`=`NOP_INSTR`, `instr_valid`=0, `fault`=0.
- `reset` asserted mid-RUN or mid-LOAD: on that edge all outputs take their reset values, and any simultaneous loader beat is not written.
- `ld_err` clears only on `reset`.
- A loader write and a fetch never coincide, because they are state-exclusive. No read-during-write behaviour is needed.

## Test plan
- Load: 4 beats write addr 0..3 = 32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213, with `ld_last` on beat 4 → `run`=1 on that edge. Then drive `pc`=0,4,8,12 on consecutive cycles → `instr` returns the same words, 1 cycle later each, with `fault`=0 and `fetch_count`=4.
- Misaligned: in RUN, `pc`=32'h0000_0002 → next cycle `instr`=32'h0000_0013, `fault`=1, `fetch_count` unchanged.
- Out of range, with `BASE_ADDR`=32'h8000_0000 and `DEPTH_WORDS`=1024:
  - `pc`=32'h8000_1000 → `fault`=1.
  - `pc`=32'h7FFF_FFFC → `fault`=1 (wrapped offset).
  - `pc`=32'h8000_0FFC → `fault`=0, returns `mem[1023]`.
- Loader error and backpressure: a beat with `ld_addr`=1024 → `ld_err`=1 and no memory word changes. After `ld_last`, `ld_valid`=1 with new data → `ld_ready`=0 and memory unchanged.
- Reset mid-RUN: assert `reset` for 1 cycle during a fetch stream → `instr`=32'h0000_0013, `instr_valid`=0, `run`=0, `fetch_count`=0, `ld_ready`=1. Re-issue `ld_last` only (no rewrites) → fetches return the originally loaded words.
- Counter saturation: force `fetch_count` to 32'hFFFF_FFFE, then perform 3 valid fetches → ends at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/imem_if.sv
// Fetch and loader signal bundle between the core/loader side and the instruction-memory responder.
interface imem_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_err;

  modport master (
    output pc, ld_valid, ld_addr, ld_data, ld_last,
    input  instr, instr_valid, fault, ld_ready, ld_err
  );

  modport slave (
    input  pc, ld_valid, ld_addr, ld_data, ld_last,
    output instr, instr_valid, fault, ld_ready, ld_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory for the fetch side: programmed through the loader port in LOAD,
// then answers one fetch per cycle in RUN with a registered word and a fault flag.
//
// state  | meaning
// S_LOAD | accepting loader beats, fetch outputs idle (NOP, not valid)
// S_RUN  | loader closed, pc sampled every edge
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  imem_if.slave       bus,
  output logic        run,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off;
  logic        fetch_fault;
  logic        ld_in_range;
  logic        ld_fire;

  // Offset wraps on purpose so a pc below the base lands out of range.
  assign off         = bus.pc - BASE_ADDR;
  assign fetch_fault = (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= DEPTH_L);
  assign ld_in_range = bus.ld_addr < DEPTH_L;
  assign ld_fire     = (state == S_LOAD) && bus.ld_valid;
  assign bus.ld_ready = (state == S_LOAD);
  assign run          = (state == S_RUN);

  // Contents survive reset; only the write is suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && ld_fire && ld_in_range)
      mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_LOAD;
      bus.instr       <= NOP_INSTR;
      bus.instr_valid <= 1'b0;
      bus.fault       <= 1'b0;
      bus.ld_err      <= 1'b0;
      fetch_count     <= 32'd0;
    end else begin
      case (state)
        S_LOAD: begin
          bus.instr       <= NOP_INSTR;
          bus.instr_valid <= 1'b0;
          bus.fault       <= 1'b0;
          if (ld_fire) begin
            if (!ld_in_range)
              bus.ld_err <= 1'b1;
            if (bus.ld_last)
              state <= S_RUN;
          end
        end
        S_RUN: begin
          bus.instr_valid <= 1'b1;
          if (fetch_fault) begin
            bus.instr <= NOP_INSTR;
            bus.fault <= 1'b1;
          end else begin
            bus.instr <= mem[off[AW+1:2]];
            bus.fault <= 1'b0;
            if (fetch_count != 32'hFFFF_FFFF)
              fetch_count <= fetch_count + 32'd1;
          end
        end
      endcase
    end
  end

endmodule
